// File: rtl/data_mem_ctrl.sv
// ---------------------------------------------------------------------------
// data_mem_ctrl
// Memory stage behind the execute ALU. Performs byte/half/word loads and
// stores on an internal word-addressed data array with a modelled access
// latency of LAT wait cycles. busy_o stalls the core while an access is in
// flight; done_o pulses once per accepted request with the load result.
//
// Parameters
//   DEPTH  number of 32-bit words (power of 2, >= 2)
//   LAT    wait cycles between accept and completion (0..15)
//
// Ports
//   clk_i    clock, all state on rising edge
//   rst_i    synchronous active-high reset
//   req_i    access request, sampled only in IDLE
//   we_i     1 = store, 0 = load
//   size_i   00 byte, 01 half, 10 word, 11 illegal
//   sign_i   load sign-extension select
//   addr_i   byte address
//   wdata_i  store data (lanes from low bits)
//   busy_o   request in flight
//   done_o   one-cycle completion pulse
//   err_o    one-cycle pulse with done_o on misaligned/illegal access
//   rdata_o  load result, held until the next legal load completion
// ---------------------------------------------------------------------------
module data_mem_ctrl #(
    parameter int DEPTH = 32,
    parameter int LAT   = 2
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        req_i,
    input  logic        we_i,
    input  logic [1:0]  size_i,
    input  logic        sign_i,
    input  logic [31:0] addr_i,
    input  logic [31:0] wdata_i,
    output logic        busy_o,
    output logic        done_o,
    output logic        err_o,
    output logic [31:0] rdata_o
);

    localparam int AW = $clog2(DEPTH);

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    state_t          state_reg;
    logic [3:0]      cnt_reg;
    logic            we_reg;
    logic [1:0]      size_reg;
    logic            sign_reg;
    logic [AW+1:0]   addr_reg;
    logic [31:0]     wdata_reg;
    logic            busy_reg;
    logic            done_reg;
    logic            err_reg;
    logic [31:0]     rdata_reg;

    logic [31:0]     mem [DEPTH];

    // Upper address bits are deliberately ignored so addresses wrap.
    logic            unused_addr_hi;
    assign unused_addr_hi = ^addr_i[31:AW+2];

    // The access being worked on: live inputs while IDLE (needed when LAT=0
    // executes on the accept edge), otherwise the captured request.
    logic            acc_we;
    logic [1:0]      acc_size;
    logic            acc_sign;
    logic [AW+1:0]   acc_addr;
    logic [31:0]     acc_wdata;

    assign acc_we    = (state_reg == IDLE) ? we_i              : we_reg;
    assign acc_size  = (state_reg == IDLE) ? size_i            : size_reg;
    assign acc_sign  = (state_reg == IDLE) ? sign_i            : sign_reg;
    assign acc_addr  = (state_reg == IDLE) ? addr_i[AW+1:0]    : addr_reg;
    assign acc_wdata = (state_reg == IDLE) ? wdata_i           : wdata_reg;

    logic [AW-1:0]   word_idx;
    assign word_idx = acc_addr[AW+1:2];

    logic illegal;
    assign illegal = (acc_size == 2'b11) ||
                     (acc_size == 2'b01 && acc_addr[0]) ||
                     (acc_size == 2'b10 && acc_addr[1:0] != 2'b00);

    // Access executes on this edge: last WAIT cycle, or accept edge when LAT=0.
    logic exec_now;
    assign exec_now = (state_reg == WAIT && cnt_reg <= 4'd1) ||
                      (state_reg == IDLE && req_i && !illegal && LAT == 0);

    logic wr_en;
    assign wr_en = exec_now && acc_we && !rst_i;

    // Per-lane write enable and write data.
    logic [3:0]       lane_en;
    logic [3:0][7:0]  lane_data;

    for (genvar gi = 0; gi < 4; gi++) begin : g_lane
        localparam logic [1:0] LANE = 2'(gi);
        assign lane_en[gi] = (acc_size == 2'b10) ||
                             (acc_size == 2'b01 && acc_addr[1] == LANE[1]) ||
                             (acc_size == 2'b00 && acc_addr[1:0] == LANE);
        assign lane_data[gi] = (acc_size == 2'b00) ? acc_wdata[7:0] :
                               (acc_size == 2'b01) ? acc_wdata[8*(gi%2) +: 8] :
                                                     acc_wdata[8*gi +: 8];
    end

    // Load path: right-justify the selected lanes, then extend.
    logic [31:0] rd_word;
    logic [31:0] rd_shift;
    logic [31:0] load_val;

    assign rd_word  = mem[word_idx];
    assign rd_shift = rd_word >> {acc_addr[1:0], 3'b000};

    always_comb begin
        load_val = rd_word;
        case (acc_size)
            2'b00:   load_val = {{24{acc_sign & rd_shift[7]}},  rd_shift[7:0]};
            2'b01:   load_val = {{16{acc_sign & rd_shift[15]}}, rd_shift[15:0]};
            default: load_val = rd_word;
        endcase
    end

    // Data array: not reset, lane-masked writes.
    always_ff @(posedge clk_i) begin
        if (wr_en) begin
            for (int i = 0; i < 4; i++) begin
                if (lane_en[i]) begin
                    mem[word_idx][8*i +: 8] <= lane_data[i];
                end
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_reg <= IDLE;
            cnt_reg   <= 4'd0;
            we_reg    <= 1'b0;
            size_reg  <= 2'b00;
            sign_reg  <= 1'b0;
            addr_reg  <= '0;
            wdata_reg <= 32'd0;
            busy_reg  <= 1'b0;
            done_reg  <= 1'b0;
            err_reg   <= 1'b0;
            rdata_reg <= 32'd0;
        end else begin
            done_reg <= 1'b0;
            err_reg  <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (req_i) begin
                        we_reg    <= we_i;
                        size_reg  <= size_i;
                        sign_reg  <= sign_i;
                        addr_reg  <= addr_i[AW+1:0];
                        wdata_reg <= wdata_i;
                        if (illegal) begin
                            state_reg <= RESP;
                            done_reg  <= 1'b1;
                            err_reg   <= 1'b1;
                        end else if (LAT == 0) begin
                            state_reg <= RESP;
                            done_reg  <= 1'b1;
                            if (!we_i) begin
                                rdata_reg <= load_val;
                            end
                        end else begin
                            state_reg <= WAIT;
                            cnt_reg   <= 4'(LAT);
                            busy_reg  <= 1'b1;
                        end
                    end
                end
                WAIT: begin
                    if (cnt_reg <= 4'd1) begin
                        state_reg <= RESP;
                        cnt_reg   <= 4'd0;
                        busy_reg  <= 1'b0;
                        done_reg  <= 1'b1;
                        if (!we_reg) begin
                            rdata_reg <= load_val;
                        end
                    end else begin
                        cnt_reg <= cnt_reg - 4'd1;
                    end
                end
                RESP: begin
                    state_reg <= IDLE;
                end
                default: begin
                    state_reg <= IDLE;
                    busy_reg  <= 1'b0;
                end
            endcase
        end
    end

    assign busy_o  = busy_reg;
    assign done_o  = done_reg;
    assign err_o   = err_reg;
    assign rdata_o = rdata_reg;

endmodule
